alu_mc: RTL and testbench
=========================

// Module: alu_mc
// PURPOSE
//   Multi-cycle, parametrised-width integer ALU with valid/ready handshakes on input and output.
//   Same 4-bit opcode map as the single-cycle ALU. RA is a true arithmetic right shift.
//   GES is a true signed >=. Shifts run iteratively, 1 bit/cycle.
//   Optional iterative multiply. Sits between decode/operand read and writeback in multi-cycle cores.
// PARAMETERS
//   WIDTH  32  datapath width; power of 2, >= 8; SHW = $clog2(WIDTH) (localparam)
// PORTS
//   clk         in   1      clock, rising edge
//   resetn      in   1      asynchronous, active-low reset
//   in_valid    in   1      operation request valid
//   in_ready    out  1      unit can accept a request this cycle
//   op          in   4      0 ADD,1 SUB,2 AND,3 RA,4 OR,5 XOR,6 LS,7 RS,8 EQ,9 NEQ,A LT,B LTS,C GE,D GES,E MUL,F illegal
//   src_a       in   WIDTH  operand A
//   src_b       in   WIDTH  operand B (shift amount = src_b[SHW-1:0], upper bits ignored)
//   out_valid   out  1      result valid
//   out_ready   in   1      consumer accepts result
//   result      out  WIDTH  operation result
//   result_err  out  1      illegal opcode flag, qualified by out_valid
//   busy        out  1      state != IDLE
// BEHAVIOUR
//   - Reset (async, resetn=0): state=IDLE, out_valid=0, result=0, result_err=0, busy=0, in_ready=1 after release.
//   - FSM: IDLE, SHIFT, MUL, DONE. Accept = in_valid & in_ready. Operands and op are latched on accept.
//   - in_ready = (state==IDLE) | (state==DONE & out_ready). Back-to-back accept is allowed while a result drains.
//   - Single-cycle ops (0-2,4,5,8-D, illegal): accepted at edge N -> DONE with result at edge N+1 (latency 1).
//   - Shifts (3,6,7) with s = shamt: s==0 -> DONE at N+1 with result = src_a.
//     s>0 -> SHIFT for s cycles, out_valid at edge N+1+s.
//     Each SHIFT cycle shifts by 1 and decrements a SHW-bit counter.
//     RA fills with the sign bit. LS/RS fill with zeros.
//   - MUL (ALU_MUL_EN only): shift-add, exactly WIDTH iterations, out_valid at edge N+1+WIDTH.
//     result = low WIDTH bits of src_a*src_b (same for signed/unsigned).
//   - Compares (8-D): result = {WIDTH-1 zeros, flag}. LT/GE unsigned; LTS/GES signed two's complement.
//   - ADD/SUB wrap modulo 2^WIDTH. No carry/overflow output.
//   - Illegal op: result=0, result_err=1, latency 1. result_err=0 for all legal ops.
//   - DONE: out_valid=1. result/result_err held stable until out_ready=1.
//     On out_ready: new accept in the same cycle -> process that op, else IDLE. out_valid drops unless the new op is single-cycle
//     (then out_valid stays 1 with the new result next edge).
//   - in_valid outside in_ready is ignored. Inputs need not be held after accept.
//   - resetn asserted mid-SHIFT/MUL aborts the op immediately. No partial result is ever presented.
// CONFIGURATION
//   ALU_MUL_EN defined: op 4'hE = MUL as above; FSM includes MUL state plus WIDTH-bit accumulator/multiplier regs.
//   ALU_MUL_EN undefined: op 4'hE treated as illegal (result 0, result_err 1, latency 1). No MUL hardware.
// TESTING (WIDTH=32 unless noted)
//   reset mid-SHIFT (RS, src_b=20, resetn low 5 cycles after accept) -> out_valid=0, result=0, in_ready=1 after release
//   ADD 0xFFFFFFFF+1, out_ready=1 -> out_valid next cycle, result=0, err=0; then SUB 0-1 back-to-back -> 0xFFFFFFFF
//   RA src_a=0x80000000, src_b=0x21 (shamt 1) -> 0xC0000000 after 2 cycles; LS shamt 0 -> src_a after 1 cycle
//   GES 5 vs 5 -> 1; LTS 0xFFFFFFFF vs 1 -> 1; LT 0xFFFFFFFF vs 1 -> 0; op 4'hF -> result 0, result_err=1
//   out_ready held 0 for 10 cycles after XOR result -> result stable, in_ready=0, new in_valid ignored
//   ALU_MUL_EN, MUL 0xFFFFFFFF*3 -> 0xFFFFFFFD, out_valid 33 cycles after accept; without macro -> result_err=1 at 1 cycle

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle integer ALU with valid/ready handshakes, iterative 1-bit/cycle shifts.
// Optional shift-add multiplier for op 4'hE, enabled by defining ALU_MUL_EN.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             result_err,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_RA  = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_LS  = 4'h6;
  localparam logic [3:0] OP_RS  = 4'h7;
  localparam logic [3:0] OP_EQ  = 4'h8;
  localparam logic [3:0] OP_NEQ = 4'h9;
  localparam logic [3:0] OP_LT  = 4'hA;
  localparam logic [3:0] OP_LTS = 4'hB;
  localparam logic [3:0] OP_GE  = 4'hC;
  localparam logic [3:0] OP_GES = 4'hD;

`ifdef ALU_MUL_EN
  localparam logic [3:0]     OP_MUL   = 4'hE;
  localparam logic [SHW-1:0] MUL_LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2,
    S_MUL   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;
`endif

  state_t           state;
  state_t           next_state;
  state_t           launch_state;
  logic             accept;
  logic [SHW-1:0]   shamt;
  logic             is_shift;
  logic [WIDTH-1:0] fast_result;
  logic             fast_err;
  logic [3:0]       op_reg;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] shifted;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] result_q;
  logic             err_q;

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] partial;
`endif

  assign accept     = in_valid & in_ready;
  assign shamt      = src_b[SHW-1:0];
  assign result     = result_q;
  assign result_err = err_q;

  // Where a freshly accepted op goes: zero-length shifts complete like single-cycle ops.
  always_comb begin
    is_shift     = (op == OP_RA) || (op == OP_LS) || (op == OP_RS);
    launch_state = S_DONE;
    if (is_shift && (shamt != '0)) begin
      launch_state = S_SHIFT;
    end
`ifdef ALU_MUL_EN
    if (op == OP_MUL) begin
      launch_state = S_MUL;
    end
`endif
  end

  always_comb begin
    fast_result = '0;
    fast_err    = 1'b0;
    case (op)
      OP_ADD:  fast_result = src_a + src_b;
      OP_SUB:  fast_result = src_a - src_b;
      OP_AND:  fast_result = src_a & src_b;
      OP_OR:   fast_result = src_a | src_b;
      OP_XOR:  fast_result = src_a ^ src_b;
      OP_RA, OP_LS, OP_RS: fast_result = src_a;
      OP_EQ:   fast_result = {{(WIDTH-1){1'b0}}, src_a == src_b};
      OP_NEQ:  fast_result = {{(WIDTH-1){1'b0}}, src_a != src_b};
      OP_LT:   fast_result = {{(WIDTH-1){1'b0}}, src_a < src_b};
      OP_LTS:  fast_result = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      OP_GE:   fast_result = {{(WIDTH-1){1'b0}}, src_a >= src_b};
      OP_GES:  fast_result = {{(WIDTH-1){1'b0}}, $signed(src_a) >= $signed(src_b)};
`ifdef ALU_MUL_EN
      OP_MUL:  fast_result = '0;
`endif
      default: fast_err = 1'b1;
    endcase
  end

  always_comb begin
    case (op_reg)
      OP_RA:   shifted = {work[WIDTH-1], work[WIDTH-1:1]};
      OP_LS:   shifted = {work[WIDTH-2:0], 1'b0};
      default: shifted = {1'b0, work[WIDTH-1:1]};
    endcase
  end

`ifdef ALU_MUL_EN
  assign partial = acc + (mplier[0] ? work : '0);
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (in_valid) next_state = launch_state;
      S_SHIFT: if (cnt == CNT_ONE) next_state = S_DONE;
`ifdef ALU_MUL_EN
      S_MUL:   if (cnt == MUL_LAST) next_state = S_DONE;
`endif
      S_DONE:  if (out_ready) next_state = in_valid ? launch_state : S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
    out_valid = (state == S_DONE);
    busy      = (state != S_IDLE);
  end

  // result_q only changes when an op completes, so no partial value is ever visible.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_reg   <= '0;
      work     <= '0;
      cnt      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
`ifdef ALU_MUL_EN
      mplier   <= '0;
      acc      <= '0;
`endif
    end else if (accept) begin
      op_reg <= op;
      work   <= src_a;
      cnt    <= shamt;
`ifdef ALU_MUL_EN
      if (op == OP_MUL) begin
        cnt    <= '0;
        mplier <= src_b;
        acc    <= '0;
      end
`endif
      if (launch_state == S_DONE) begin
        result_q <= fast_result;
        err_q    <= fast_err;
      end
    end else begin
      case (state)
        S_SHIFT: begin
          work <= shifted;
          cnt  <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            result_q <= shifted;
            err_q    <= 1'b0;
          end
        end
`ifdef ALU_MUL_EN
        S_MUL: begin
          acc    <= partial;
          work   <= work << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_ONE;
          if (cnt == MUL_LAST) begin
            result_q <= partial;
            err_q    <= 1'b0;
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: driver queues hand-computed expectations,
// a negedge monitor checks result, error flag, latency and hold stability.
module tb_alu_mc;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             resetn;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             result_err;
  logic             busy;

  alu_mc #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .result_err (result_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             err;
    int               lat;
    int               acc_cyc;
    string            name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_value(input string name, input logic [WIDTH-1:0] act,
                             input logic [WIDTH-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: actual 0x%08h required 0x%08h", name, act, req);
    end
  endtask

  // Monitor: the first valid cycle of each result is compared against the queue,
  // later valid cycles (consumer stalled) must hold the same value.
  logic             fresh = 1'b1;
  logic [WIDTH-1:0] held_res;
  logic             held_err;
  exp_t             mon_e;

  always @(negedge clk) begin
    if (!resetn) begin
      fresh = 1'b1;
    end else if (out_valid) begin
      if (fresh) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_output: actual 0x%08h required none", result);
        end else begin
          mon_e = sb.pop_front();
          check_value({mon_e.name, " result"}, result, mon_e.res);
          check_value({mon_e.name, " err"}, {{(WIDTH-1){1'b0}}, result_err},
                      {{(WIDTH-1){1'b0}}, mon_e.err});
          check_value({mon_e.name, " latency"}, WIDTH'(cyc - mon_e.acc_cyc), WIDTH'(mon_e.lat));
        end
        held_res = result;
        held_err = result_err;
        fresh    = 1'b0;
      end else begin
        check_value("hold result", result, held_res);
        check_value("hold err", {{(WIDTH-1){1'b0}}, result_err}, {{(WIDTH-1){1'b0}}, held_err});
      end
      if (out_ready) fresh = 1'b1;
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic apply_stimulus(input string name, input logic [3:0] o,
                                input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic [WIDTH-1:0] exp_res, input logic exp_err,
                                input int lat, input bit push);
    int waited = 0;
    in_valid = 1'b1;
    op       = o;
    src_a    = a;
    src_b    = b;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s accept_timeout: actual in_ready 0 required 1", name);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      return;
    end
    if (push) sb.push_back('{exp_res, exp_err, lat, cyc, name});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op       = 4'h0;
    src_a    = 32'hDEAD_BEEF;
    src_b    = 32'h0BAD_F00D;
  endtask

  initial begin
    int w;
    resetn    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = 4'h0;
    src_a     = '0;
    src_b     = '0;
    #1;
    check_value("reset out_valid", {31'b0, out_valid}, 32'd0);
    check_value("reset result", result, 32'd0);
    check_value("reset err", {31'b0, result_err}, 32'd0);
    check_value("reset busy", {31'b0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    check_value("reset in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    apply_stimulus("add_wrap", 4'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1, 1);
    apply_stimulus("sub_wrap", 4'h1, 32'h0, 32'h1, 32'hFFFF_FFFF, 1'b0, 1, 1);

    // Abort a long right shift with reset; the stale SUB result must be cleared.
    apply_stimulus("rs_abort", 4'h7, 32'hF000_0000, 32'd20, 32'h0, 1'b0, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    check_value("abort busy before reset", {31'b0, busy}, 32'd1);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    check_value("abort out_valid", {31'b0, out_valid}, 32'd0);
    check_value("abort result", result, 32'd0);
    check_value("abort busy", {31'b0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    check_value("abort in_ready", {31'b0, in_ready}, 32'd1);
    check_value("abort out_valid after", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;

    apply_stimulus("ra_1",     4'h3, 32'h8000_0000, 32'h21, 32'hC000_0000, 1'b0, 2,  1);
    apply_stimulus("ls_0",     4'h6, 32'h1234_5678, 32'h40, 32'h1234_5678, 1'b0, 1,  1);
    apply_stimulus("rs_4",     4'h7, 32'h8000_0000, 32'd4,  32'h0800_0000, 1'b0, 5,  1);
    apply_stimulus("ls_31",    4'h6, 32'h0000_0001, 32'd31, 32'h8000_0000, 1'b0, 32, 1);
    apply_stimulus("ra_pos_3", 4'h3, 32'h4000_0000, 32'd3,  32'h0800_0000, 1'b0, 4,  1);
    apply_stimulus("ra_31",    4'h3, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 32, 1);
    apply_stimulus("ges_eq",   4'hD, 32'd5,         32'd5,  32'd1, 1'b0, 1, 1);
    apply_stimulus("lts_neg",  4'hB, 32'hFFFF_FFFF, 32'd1,  32'd1, 1'b0, 1, 1);
    apply_stimulus("lt_uns",   4'hA, 32'hFFFF_FFFF, 32'd1,  32'd0, 1'b0, 1, 1);
    apply_stimulus("ge_uns",   4'hC, 32'hFFFF_FFFF, 32'd1,  32'd1, 1'b0, 1, 1);
    apply_stimulus("ges_neg",  4'hD, 32'hFFFF_FFFF, 32'd1,  32'd0, 1'b0, 1, 1);
    apply_stimulus("eq",       4'h8, 32'd7,         32'd7,  32'd1, 1'b0, 1, 1);
    apply_stimulus("neq",      4'h9, 32'd7,         32'd7,  32'd0, 1'b0, 1, 1);
    apply_stimulus("and",      4'h2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1, 1);
    apply_stimulus("or",       4'h4, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 1'b0, 1, 1);
    apply_stimulus("illegal",  4'hF, 32'h1234_5678, 32'h1,  32'h0, 1'b1, 1, 1);
    apply_stimulus("add_small", 4'h0, 32'd2,        32'd3,  32'd5, 1'b0, 1, 1);
`ifdef ALU_MUL_EN
    apply_stimulus("mul",      4'hE, 32'hFFFF_FFFF, 32'd3,  32'hFFFF_FFFD, 1'b0, 33, 1);
`else
    apply_stimulus("mul_off",  4'hE, 32'hFFFF_FFFF, 32'd3,  32'h0, 1'b1, 1, 1);
`endif

    // Stall the consumer on an XOR result; other requests must be ignored meanwhile.
    repeat (40) @(posedge clk);
    #1;
    out_ready = 1'b0;
    apply_stimulus("xor_stall", 4'h5, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F, 1'b0, 1, 1);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      op       = 4'h0;
      src_a    = 32'd1;
      src_b    = 32'd1;
      @(negedge clk);
      check_value("stall in_ready", {31'b0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    apply_stimulus("after_stall", 4'h1, 32'd10, 32'd3, 32'd7, 1'b0, 1, 1);

    w = 0;
    while ((sb.size() != 0 || out_valid) && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (sb.size() != 0 || out_valid) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL drain_timeout: actual %0d pending required 0", sb.size());
    end
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
